// File: rtl/sqrt_param_iter.sv
// Iterative integer square root: one result bit per clock via restoring bit-pair recurrence.
// Optional build macro SQRT_ROUND_EN rounds the result to nearest (saturating); default is floor.
module sqrt_param_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     num,
    output logic                 ready,
    output logic                 done,
    output logic [WIDTH/2-1:0]   result,
    output logic [WIDTH/2:0]     remainder
);

    localparam int RW = WIDTH / 2;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [RW-1:0] ROOT_MAX = {RW{1'b1}};
    localparam logic [RW-1:0] ROOT_ONE = RW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [RW-1:0]      r_root;
    logic [RW:0]        r_rem;
    logic [CW-1:0]      r_cnt;

    logic [1:0]         w_pair;
    logic [RW+2:0]      w_cat;
    logic [RW+2:0]      w_sub;
    logic               w_ge;
    logic [RW-1:0]      w_root_nx;
    logic [RW:0]        w_rem_nx;
    logic [RW-1:0]      w_res;

    // One recurrence step: the trial subtraction is non-negative exactly when cat >= sub.
    always_comb begin
        w_pair    = r_shift[WIDTH-1 -: 2];
        w_cat     = {r_rem, w_pair};
        w_sub     = {1'b0, r_root, 2'b01};
        w_ge      = (w_cat >= w_sub);
        w_root_nx = RW'({r_root, w_ge});
        if (w_ge) begin
            w_rem_nx = (RW+1)'(w_cat - w_sub);
        end else begin
            w_rem_nx = (RW+1)'(w_cat);
        end
        w_res = w_root_nx;
`ifdef SQRT_ROUND_EN
        // Remainder above the root means the true root is at least floor + 0.5.
        if (({1'b0, w_root_nx} < w_rem_nx) && (w_root_nx != ROOT_MAX)) begin
            w_res = w_root_nx + ROOT_ONE;
        end else begin
            w_res = w_root_nx;
        end
`endif
    end

    // Controller and datapath registers, including the registered handshake outputs.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_root    <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_shift <= num;
                        r_root  <= '0;
                        r_rem   <= '0;
                        r_cnt   <= CNT_INIT;
                        ready   <= 1'b0;
                        r_state <= S_CALC;
                    end else begin
                        ready   <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_shift <= r_shift << 2;
                    r_root  <= w_root_nx;
                    r_rem   <= w_rem_nx;
                    if (r_cnt == CNT_ZERO) begin
                        result    <= w_res;
                        remainder <= w_rem_nx;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt     <= r_cnt - CNT_ONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_param_iter.sv
// Self-checking bench for sqrt_param_iter (WIDTH=8) against an arithmetic square-root model.
module tb_sqrt_param_iter;

    localparam int W  = 8;
    localparam int RW = W / 2;

    logic            clk;
    logic            clear;
    logic            start;
    logic [W-1:0]    num;
    logic            ready;
    logic            done;
    logic [RW-1:0]   result;
    logic [RW:0]     remainder;

    int n_checks;
    int n_pass;

    sqrt_param_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .num       (num),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_root(input int n);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    function automatic int model_result(input int n);
        int r;
        int rem;
        r   = model_root(n);
        rem = n - r * r;
`ifdef SQRT_ROUND_EN
        if (rem > r && r < (1 << RW) - 1) r = r + 1;
`endif
        return r;
    endfunction

    task automatic run_op(input int n, input string name, input bit check_lat);
        int lat;
        int exp_res;
        int exp_rem;
        bit seen;
        exp_res = model_result(n);
        exp_rem = n - model_root(n) * model_root(n);
        @(negedge clk);
        start = 1'b1;
        num   = W'(n);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        num   = W'($urandom);
        n_checks++;
        if (ready !== 1'b0) $display("FAIL %s busy: ready=%0b expected 0", name, ready);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL %s timeout: done never seen, expected within %0d clocks", name, RW + 1);
            return;
        end else n_pass++;
        if (check_lat) begin
            n_checks++;
            if (lat != RW + 1) $display("FAIL %s latency: got %0d expected %0d", name, lat, RW + 1);
            else n_pass++;
        end
        n_checks++;
        if (result !== RW'(exp_res) || remainder !== (RW+1)'(exp_rem))
            $display("FAIL %s value num=%0d: got %0d/%0d expected %0d/%0d",
                     name, n, result, remainder, exp_res, exp_rem);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0)
            $display("FAIL %s after_done: ready=%0b done=%0b expected 1/0", name, ready, done);
        else n_pass++;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        start = 1'b0;
        num   = '0;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || result !== '0 || remainder !== '0)
            $display("FAIL reset: ready=%0b done=%0b result=%0d rem=%0d expected 1/0/0/0",
                     ready, done, result, remainder);
        else n_pass++;
    endtask

    task automatic test_directed();
        run_op(49, "num49", 1'b1);
        run_op(0, "num0", 1'b0);
        run_op(255, "num255", 1'b1);
        run_op(48, "num48", 1'b0);
        run_op(56, "num56", 1'b0);
        run_op(57, "num57", 1'b0);
        run_op(1, "num1", 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            run_op(int'($urandom_range(255, 0)), "random", 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        int last;
        n_done = 0;
        last   = -1;
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) begin
                n_done++;
                n_checks++;
                if (result !== RW'(10) || remainder !== '0)
                    $display("FAIL b2b value: got %0d/%0d expected 10/0", result, remainder);
                else n_pass++;
                if (last >= 0) begin
                    n_checks++;
                    if (i - last != RW + 2)
                        $display("FAIL b2b spacing: got %0d expected %0d", i - last, RW + 2);
                    else n_pass++;
                end
                last = i;
            end
            start = (i < 20);
            num   = (ready === 1'b1) ? W'(100) : W'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (n_done != 4) $display("FAIL b2b count: got %0d done pulses expected 4", n_done);
        else n_pass++;
    endtask

    task automatic test_clear_abort();
        bit saw_done;
        @(negedge clk);
        start = 1'b1;
        num   = W'(200);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        clear = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || result !== '0 || remainder !== '0)
            $display("FAIL abort: ready=%0b done=%0b result=%0d rem=%0d expected 1/0/0/0",
                     ready, done, result, remainder);
        else n_pass++;
        @(negedge clk);
        clear = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) $display("FAIL abort_nodone: got a done pulse expected none");
        else n_pass++;
        run_op(16, "after_abort16", 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear    = 1'b1;
        start    = 1'b0;
        num      = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_clear_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
